// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: pipeline request/response and cache port bundle for the load/store controller
interface lsu_mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [DATA_W-1:0] req_wdata_i;
   logic              resp_valid_o;
   logic [DATA_W-1:0] resp_rdata_o;
   logic              resp_err_o;
   logic              cache_re_o;
   logic [ADDR_W-1:0] cache_raddr_o;
   logic [DATA_W-1:0] cache_rdata_i;
   logic              cache_we_o;
   logic [ADDR_W-1:0] cache_waddr_o;
   logic [DATA_W-1:0] cache_wdata_o;
   modport master (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, cache_rdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
             cache_re_o, cache_raddr_o, cache_we_o, cache_waddr_o, cache_wdata_o
   );
   modport slave (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, cache_rdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
             cache_re_o, cache_raddr_o, cache_we_o, cache_waddr_o, cache_wdata_o
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte/half/word load-store sequencer with read-modify-write toward a byte-swapped cache
module lsu_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic            clk_i,
   input logic            rst_ni,
   lsu_mem_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q, addr_al;
   logic [1:0]        size_q;
   logic              we_q, uns_q, err_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              accept, misaligned, sext;
   logic [DATA_W-1:0] rd_le, ld_data, merged;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;

   assign accept     = (state == IDLE) && bus.req_valid_i;
   assign misaligned = (bus.req_size_i == 2'b11)
                    || (bus.req_size_i == 2'b01 && bus.req_addr_i[0])
                    || (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
   assign addr_al    = {addr_q[ADDR_W-1:2], 2'b00};
   // the cache returns offset 0 in the top byte; swap to little-endian lane order
   assign rd_le      = {bus.cache_rdata_i[7:0], bus.cache_rdata_i[15:8],
                        bus.cache_rdata_i[23:16], bus.cache_rdata_i[31:24]};
   assign ld_byte    = rd_le[{addr_q[1:0], 3'b000} +: 8];
   assign ld_half    = addr_q[1] ? rd_le[31:16] : rd_le[15:0];
   assign sext       = ~uns_q;
   assign ld_data    = size_q == 2'b00 ? {{24{sext & ld_byte[7]}}, ld_byte}
                     : size_q == 2'b01 ? {{16{sext & ld_half[15]}}, ld_half}
                     : rd_le;
   assign bus.resp_rdata_o = rdata_q;
   assign bus.resp_err_o   = err_q;

   // state register
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;

   // next-state: errors skip the cache, word stores skip the read, everything else reads first
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid_i)
                     state_nxt = misaligned ? RESP
                               : (bus.req_we_i && bus.req_size_i == 2'b10) ? WR : RD;
         RD:      state_nxt = we_q ? WR : RESP;
         WR:      state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   // merge the store lane into the little-endian view of the word just read
   always_comb begin
      merged = rd_le;
      if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // request latch; response data only changes on the edge that enters RESP
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= bus.req_addr_i;
            size_q  <= bus.req_size_i;
            we_q    <= bus.req_we_i;
            uns_q   <= bus.req_unsigned_i;
            wdata_q <= bus.req_wdata_i;
         end
         if (accept && misaligned) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
         if (state == RD && !we_q) begin
            rdata_q <= ld_data;
            err_q   <= 1'b0;
         end
         if (state == RD && we_q) wdata_q <= merged;
         if (state == WR) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end

   // outputs decode from registered state only
   always_comb begin
      bus.req_ready_o   = state == IDLE;
      bus.resp_valid_o  = state == RESP;
      bus.cache_re_o    = state == RD;
      bus.cache_raddr_o = state == RD ? addr_al : '0;
      bus.cache_we_o    = state == WR;
      bus.cache_waddr_o = state == WR ? addr_al : '0;
      bus.cache_wdata_o = state == WR ? wdata_q : '0;
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of loads, stores, RMW, errors, back-to-back and mid-op reset
module tb_lsu_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0, failures = 0;
   int          re_cnt = 0, we_cnt = 0, resp_cnt = 0, cyc = 0, re_cyc = 0, we_cyc = 0;
   logic [31:0] last_wdata = '0;
   logic [31:0] mem [256];
   int          re0, we0, resp0;

   lsu_mem_ctrl_if bus ();
   lsu_mem_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // cache model: stores little-endian words, returns them with offset 0 in the top byte
   assign bus.cache_rdata_i = bus.cache_re_o ? bswap(mem[bus.cache_raddr_o[9:2]]) : 32'h0;
   always @(posedge clk) if (bus.cache_we_o) mem[bus.cache_waddr_o[9:2]] <= bus.cache_wdata_o;

   // activity monitor sampled away from the active edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus.cache_re_o) begin re_cnt <= re_cnt + 1; re_cyc <= cyc; end
      if (bus.cache_we_o) begin we_cnt <= we_cnt + 1; we_cyc <= cyc; last_wdata <= bus.cache_wdata_o; end
      if (bus.resp_valid_o) resp_cnt <= resp_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_re, input int exp_we);
      int r0, w0, lat;
      r0 = re_cnt;
      w0 = we_cnt;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
      bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = sz;
      bus.req_unsigned_i = uns; bus.req_addr_i = a; bus.req_wdata_i = wd;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.resp_valid_o && lat < 8);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_rdata"}, bus.resp_rdata_o, exp_rd);
      chk({tag, "_err"}, 32'(bus.resp_err_o), 32'(exp_err));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(bus.resp_valid_o), 32'd0);
      chk({tag, "_re_n"}, 32'(re_cnt - r0), 32'(exp_re));
      chk({tag, "_we_n"}, 32'(we_cnt - w0), 32'(exp_we));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      chk("rst_rdata", bus.resp_rdata_o, 32'h0);
      chk("rst_err", 32'(bus.resp_err_o), 32'd0);
      chk("rst_cache_en", {30'd0, bus.cache_re_o, bus.cache_we_o}, 32'd0);
      chk("rst_cache_bus", bus.cache_raddr_o | bus.cache_waddr_o | bus.cache_wdata_o, 32'h0);
      rst_n = 1'b1;

      txn("sw",   1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
      chk("sw_wdata", last_wdata, 32'h11223344);
      txn("lw",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 32'h11223344, 1'b0, 1, 0);
      txn("lbu0", 1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 2, 32'h00000044, 1'b0, 1, 0);
      txn("lbu3", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 2, 32'h00000011, 1'b0, 1, 0);

      txn("sb",   1'b1, 2'b00, 1'b0, 32'h101, 32'h123456F0, 3, 32'h0, 1'b0, 1, 1);
      chk("sb_wdata", last_wdata, 32'h1122F044);
      chk("sb_order", 32'(we_cyc - re_cyc), 32'd1);
      txn("lbu1", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 2, 32'h000000F0, 1'b0, 1, 0);
      txn("lb1",  1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 2, 32'hFFFFFFF0, 1'b0, 1, 0);

      txn("sh",   1'b1, 2'b01, 1'b0, 32'h102, 32'hAAAABEEF, 3, 32'h0, 1'b0, 1, 1);
      chk("sh_wdata", last_wdata, 32'hBEEFF044);
      txn("lh",   1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 2, 32'hFFFFBEEF, 1'b0, 1, 0);
      txn("lhu",  1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 2, 32'h0000BEEF, 1'b0, 1, 0);

      txn("err_lw",   1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      txn("lhu_ok",   1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 2, 32'h0000F044, 1'b0, 1, 0);
      txn("err_sh",   1'b1, 2'b01, 1'b0, 32'h103, 32'h5555, 1, 32'h0, 1'b1, 0, 0);
      txn("err_size", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      chk("err_mem", mem[8'h40], 32'hBEEFF044);

      resp0 = resp_cnt;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'b10;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h100;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clk);
         chk("b2b_ready", 32'(bus.req_ready_o), 32'(k % 3 == 0));
         chk("b2b_resp", 32'(bus.resp_valid_o), 32'(k % 3 == 2));
         if (k % 3 == 2) chk("b2b_rdata", bus.resp_rdata_o, 32'hBEEFF044);
      end
      bus.req_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("b2b_resp_cnt", 32'(resp_cnt - resp0), 32'd3);

      we0 = we_cnt;
      resp0 = resp_cnt;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b00;
      bus.req_addr_i = 32'h100; bus.req_wdata_i = 32'h000000AA;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      chk("rst_mid_re_before", 32'(bus.cache_re_o), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_re", 32'(bus.cache_re_o), 32'd0);
      chk("rst_mid_we", 32'(bus.cache_we_o), 32'd0);
      chk("rst_mid_raddr", bus.cache_raddr_o, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid_we_n", 32'(we_cnt - we0), 32'd0);
      chk("rst_mid_resp_n", 32'(resp_cnt - resp0), 32'd0);
      chk("rst_mid_mem", mem[8'h40], 32'hBEEFF044);
      chk("rst_mid_ready", 32'(bus.req_ready_o), 32'd1);
      chk("rst_mid_rdata", bus.resp_rdata_o, 32'h0);
      chk("rst_mid_err", 32'(bus.resp_err_o), 32'd0);
      txn("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 32'hBEEFF044, 1'b0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
